// File: rtl/iter_divider.sv
// iter_divider: iterative radix-2 restoring divider for RV32M-style
// div/divu/rem/remu. One quotient bit per CALC cycle. Divide-by-zero and
// signed overflow can optionally bypass the iteration.
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             sel_rem;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] dvs_mag;

  // Two's-complement negate when neg is set; also yields absolute values.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // op[2] only separates divides from multiplies upstream; every op reaching
  // this block is a divide.
  logic op_unused;
  assign op_unused = op[2];

  // Operand decode, used only on the accepting start edge.
  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic             sgn_ovf;
  logic             fast_case;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] fast_quo;
  logic [WIDTH-1:0] fast_rem;

  assign is_signed = ~op[0];
  assign sign_a    = is_signed & dividend[WIDTH-1];
  assign sign_b    = is_signed & divisor[WIDTH-1];
  assign mag_a     = cond_neg(dividend, sign_a);
  assign mag_b     = cond_neg(divisor, sign_b);
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (divisor == '1);
  assign fast_case = FAST_ZERO && (div_zero || sgn_ovf);
  assign fast_quo  = div_zero ? '1 : dividend;
  assign fast_rem  = div_zero ? dividend : '0;

  // One restoring step on a WIDTH+1-bit partial remainder; dividend MSB first.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign shifted  = {rem_acc, quo_acc[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_mag};
  assign quo_next = {quo_acc[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_fix  = cond_neg(quo_next, neg_quo);
  assign rem_fix  = cond_neg(rem_next, neg_rem);

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      result    <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem <= op[1];
            // A zero divisor keeps the all-ones quotient regardless of sign.
            neg_quo <= (sign_a ^ sign_b) & ~div_zero;
            neg_rem <= sign_a;
            quo_acc <= mag_a;
            dvs_mag <= mag_b;
            rem_acc <= '0;
            cnt     <= CW'(WIDTH-1);
            if (fast_case) begin
              quotient  <= fast_quo;
              remainder <= fast_rem;
              result    <= op[1] ? fast_rem : fast_quo;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            quo_acc <= quo_next;
            rem_acc <= rem_next;
            if (cnt == '0) begin
              quotient  <= quo_fix;
              remainder <= rem_fix;
              result    <= sel_rem ? rem_fix : quo_fix;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; legal values 8..64.
REQ-002 SHALL have parameter FAST_ZERO, default 1; when 1, divide-by-zero and signed-overflow complete via the fast path.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels an in-flight division.
REQ-007 SHALL have port op  input  3  RV32M funct3 encoding: 100 div, 101 divu, 110 rem, 111 remu.
REQ-008 SHALL have port dividend  input  WIDTH  numerator, sampled with start.
REQ-009 SHALL have port divisor  input  WIDTH  denominator, sampled with start.
REQ-010 SHALL have port busy  output  1  high in CALC.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-013 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-014 SHALL have port result  output  WIDTH  quotient for div/divu, remainder for rem/remu, per latched op.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start, IDLE->DONE on start with fast-path case, CALC->DONE after WIDTH iterations, CALC->IDLE on abort, DONE->IDLE unconditionally.
REQ-016 SHALL latch op, operand signs and operand magnitudes on the start edge; input changes afterwards have no effect.
REQ-017 SHALL treat op[0]=1 as unsigned and op[0]=0 as signed; signed magnitudes are two's-complement absolute values.
REQ-018 SHALL perform one restoring radix-2 step per CALC cycle on a WIDTH+1-bit partial remainder, MSB of dividend first; iteration counter runs WIDTH-1 down to 0 without wrap.
REQ-019 SHALL, on the transition into DONE, negate quotient when operand signs differ (signed only) and negate remainder when dividend is negative (signed only).
REQ-020 SHALL assert done exactly in the DONE cycle: WIDTH+1 cycles after the start sample for normal ops, 1 cycle for fast path.
REQ-021 SHALL, for divisor==0, produce quotient all-ones and remainder = dividend (both signed and unsigned).
REQ-022 SHALL, for signed dividend = -2^(WIDTH-1) and divisor = -1, produce quotient = dividend and remainder = 0.
REQ-023 SHALL, when FAST_ZERO=0, run REQ-021/022 cases through full CALC latency with identical results.
REQ-024 SHALL hold quotient, remainder, result stable from DONE until the next accepted start.
REQ-025 SHALL ignore start while in CALC or DONE; no queuing.
REQ-026 SHALL, on abort in CALC, return to IDLE next cycle, not pulse done, leave quotient/remainder at previous completed values.
REQ-027 SHALL ignore abort in IDLE and DONE; abort and start both high in IDLE: abort ignored, start accepted.
REQ-028 SHALL assert busy only in CALC; busy and done never high together.

Reset
REQ-029 SHALL, while rst==0 at a rising edge, enter IDLE, clear busy, done, quotient, remainder, result and iteration counter to 0.
REQ-030 SHALL honour reset in any state, including mid-CALC, with no done pulse and no partial result visible.
REQ-031 SHALL give reset priority over start and abort.

Verification
REQ-032 SHALL cover divu 100/7, WIDTH=32 -> done at cycle 33, quotient 14, remainder 2, result 14.
REQ-033 SHALL cover div and rem -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; result per op.
REQ-034 SHALL cover divu 0x1234/0 and div 0x80000000/0xFFFFFFFF -> done after 1 cycle; quotient 0xFFFFFFFF rem 0x1234; quotient 0x80000000 rem 0.
REQ-035 SHALL cover abort at CALC cycle 10, then start while busy, then reset at CALC cycle 5 -> no done, busy drops next cycle, second start ignored, outputs 0 after reset.
REQ-036 SHALL cover WIDTH=8 random signed/unsigned sweep, including divisor 0 and -128/-1, against a reference model; latency 9 or 1 cycles.
